// File: rtl/mux_key_table_pkg.sv
// Shared helpers for the programmable key lookup table and its priority matcher.
// Width-dependent structs live in the modules, where the widths are known.
package mux_key_table_pkg;

    // Index width for a table of nr_key entries; never narrower than one bit.
    function automatic int idx_len(input int nr_key);
        return (nr_key > 1) ? $clog2(nr_key) : 1;
    endfunction

    // Width-independent part of a match result.
    typedef struct packed {
        logic hit;
        logic multi;
    } match_flags_t;

endpackage

// File: rtl/mux_key_match.sv
// Combinational priority matcher: the lowest valid entry whose key equals the
// lookup key wins; multi flags a second valid match anywhere above it.
module mux_key_match
    import mux_key_table_pkg::*;
#(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 4,
    parameter int DATA_LEN = 8,
    parameter int IDX_LEN  = idx_len(NR_KEY)
) (
    input  logic [NR_KEY-1:0]               ent_vld,
    input  logic [NR_KEY-1:0][KEY_LEN-1:0]  ent_key,
    input  logic [NR_KEY-1:0][DATA_LEN-1:0] ent_data,
    input  logic [KEY_LEN-1:0]              key,
    output match_flags_t                    flags,
    output logic [IDX_LEN-1:0]              idx,
    output logic [DATA_LEN-1:0]             data
);

    always_comb begin
        flags = '0;
        idx   = '0;
        data  = '0;
        // Ascending scan so the first match found is the lowest index.
        for (int i = 0; i < NR_KEY; i++) begin
            if (ent_vld[i] && (ent_key[i] == key)) begin
                if (flags.hit) begin
                    flags.multi = 1'b1;
                end else begin
                    flags.hit = 1'b1;
                    idx       = IDX_LEN'(i);
                    data      = ent_data[i];
                end
            end
        end
    end

endmodule

// File: rtl/mux_key_table.sv
// Programmable key-to-data lookup table with a registered, one-cycle-latency
// valid/ready response channel.
module mux_key_table
    import mux_key_table_pkg::*;
#(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 4,
    parameter int DATA_LEN    = 8,
    parameter int HAS_DEFAULT = 1,
    parameter int IDX_LEN     = idx_len(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_LEN-1:0]  wr_idx,
    input  logic                wr_vld,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_LEN-1:0] resp_data,
    output logic                resp_hit,
    output logic [IDX_LEN-1:0]  resp_idx,
    output logic                resp_multi
);

    typedef struct packed {
        logic                vld;
        logic [KEY_LEN-1:0]  key;
        logic [DATA_LEN-1:0] data;
    } entry_t;

    typedef struct packed {
        logic [DATA_LEN-1:0] data;
        logic                hit;
        logic [IDX_LEN-1:0]  idx;
        logic                multi;
    } resp_t;

    entry_t [NR_KEY-1:0]           entries;
    logic [NR_KEY-1:0]             ent_vld;
    logic [NR_KEY-1:0][KEY_LEN-1:0]  ent_key;
    logic [NR_KEY-1:0][DATA_LEN-1:0] ent_data;

    match_flags_t        match_flags_p0;
    logic [IDX_LEN-1:0]  match_idx_p0;
    logic [DATA_LEN-1:0] match_data_p0;
    resp_t               resp_p0;
    resp_t               resp_p1;
    logic                vld_p1;
    logic                accept;

    always_comb begin
        ent_vld  = '0;
        ent_key  = '0;
        ent_data = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            ent_vld[i]  = entries[i].vld;
            ent_key[i]  = entries[i].key;
            ent_data[i] = entries[i].data;
        end
    end

    // Entry storage. Indices at or above NR_KEY never compare equal, so such
    // writes fall through without touching the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entries <= '0;
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (wr_en && (wr_idx == IDX_LEN'(i))) begin
                    entries[i] <= {wr_vld, wr_key, wr_data};
                end
            end
        end
    end

    // Stage p0: match against the pre-edge table contents.
    mux_key_match #(
        .NR_KEY   (NR_KEY),
        .KEY_LEN  (KEY_LEN),
        .DATA_LEN (DATA_LEN),
        .IDX_LEN  (IDX_LEN)
    ) u_match (
        .ent_vld  (ent_vld),
        .ent_key  (ent_key),
        .ent_data (ent_data),
        .key      (req_key),
        .flags    (match_flags_p0),
        .idx      (match_idx_p0),
        .data     (match_data_p0)
    );

    always_comb begin
        resp_p0       = '0;
        resp_p0.hit   = match_flags_p0.hit;
        resp_p0.multi = match_flags_p0.multi;
        resp_p0.idx   = match_idx_p0;
        if (match_flags_p0.hit) begin
            resp_p0.data = match_data_p0;
        end else if (HAS_DEFAULT != 0) begin
            resp_p0.data = default_out;
        end
    end

    assign req_ready = !vld_p1 || resp_ready;
    assign accept    = req_valid && req_ready;

    // Stage p1: response register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            resp_p1 <= '0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            resp_p1 <= resp_p0;
        end else if (resp_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign resp_valid = vld_p1;
    assign resp_data  = resp_p1.data;
    assign resp_hit   = resp_p1.hit;
    assign resp_idx   = resp_p1.idx;
    assign resp_multi = resp_p1.multi;

endmodule
